reg_wb_unit: RTL and testbench

Write-back stage and architectural register file directly downstream of the execute-stage ALU. Each cycle it commits at most one result: the ALU result, or an entry from a small load-return queue fed by the load/store unit. It provides two bypassed read ports to decode. A per-register busy scoreboard lets issue logic stall on outstanding loads.

---
 rtl/reg_wb_unit_pkg.sv | 18 +
 rtl/reg_wb_unit_if.sv | 43 ++++
 rtl/reg_wb_unit_wb_load_queue.sv | 55 +++++
 rtl/reg_wb_unit.sv | 106 ++++++++++
 tb/tb_reg_wb_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_unit_pkg.sv
// Shared constants and the load-return payload for the write-back stage.
// XLEN tracks the core's MAX_BIT_POS; 31 is the fallback when config.v has not defined it.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

package reg_wb_unit_pkg;

   localparam int unsigned XLEN     = `MAX_BIT_POS + 1;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } lq_entry_t;

endpackage

// File: rtl/reg_wb_unit_if.sv
// Bus bundle between execute/LSU/decode and the write-back stage.
interface reg_wb_unit_if
   import reg_wb_unit_pkg::*;
#(
   parameter int unsigned LQ_DEPTH = 2
);
   localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

   logic              alu_en;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              ld_valid;
   logic              ld_ready;
   logic [REG_AW-1:0] ld_rd;
   logic [XLEN-1:0]   ld_data;
   logic              ld_issue;
   logic [REG_AW-1:0] ld_issue_rd;
   logic [REG_AW-1:0] rs1_addr;
   logic [REG_AW-1:0] rs2_addr;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic              rs1_busy;
   logic              rs2_busy;
   logic              wb_en;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic [CW-1:0]     lq_count;

   modport master (
      output alu_en, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
             ld_issue, ld_issue_rd, rs1_addr, rs2_addr,
      input  ld_ready, rs1_data, rs2_data, rs1_busy, rs2_busy,
             wb_en, wb_rd, wb_data, lq_count
   );

   modport slave (
      input  alu_en, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
             ld_issue, ld_issue_rd, rs1_addr, rs2_addr,
      output ld_ready, rs1_data, rs2_data, rs1_busy, rs2_busy,
             wb_en, wb_rd, wb_data, lq_count
   );

endinterface

// File: rtl/reg_wb_unit_wb_load_queue.sv
// In-order load-return FIFO; pointers wrap naturally since DEPTH is a power of two.
module wb_load_queue
   import reg_wb_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  lq_entry_t                    i_entry,
   input  logic                         i_pop,
   output lq_entry_t                    o_head,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH):0]       o_count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   lq_entry_t       r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_entry;
   end

endmodule

// File: rtl/reg_wb_unit.sv
// Write-back stage: ALU/load arbitration, 32-entry register file, busy scoreboard
// and bypassed read ports for decode.
module reg_wb_unit
   import reg_wb_unit_pkg::*;
#(
   parameter int unsigned LQ_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   reg_wb_unit_if.slave  bus
);
   localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

   logic [XLEN-1:0]     r_rf [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic                r_wb_en;
   logic [REG_AW-1:0]   r_wb_rd;
   logic [XLEN-1:0]     r_wb_data;

   lq_entry_t           w_ld_entry;
   lq_entry_t           w_head;
   logic                w_full;
   logic                w_empty;
   logic [CW-1:0]       w_count;
   logic                w_alu_wr;
   logic                w_pop;
   logic                w_wr_en;
   logic [REG_AW-1:0]   w_wr_rd;
   logic [XLEN-1:0]     w_wr_data;
   logic [NUM_REGS-1:0] w_busy_nxt;

   assign w_ld_entry = '{rd: bus.ld_rd, data: bus.ld_data};

   wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
      .clk     (clk),
      .rst     (rst),
      .i_push  (bus.ld_valid),
      .i_entry (w_ld_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // ALU to x0 yields the port, so a queued load can still drain that cycle.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_rd   = '0;
      w_wr_data = '0;
      w_alu_wr  = bus.alu_en && (bus.alu_rd != '0);
      w_pop     = !w_alu_wr && !w_empty;
      if (w_alu_wr) begin
         w_wr_en   = 1'b1;
         w_wr_rd   = bus.alu_rd;
         w_wr_data = bus.alu_data;
      end else if (w_pop && (w_head.rd != '0)) begin
         w_wr_en   = 1'b1;
         w_wr_rd   = w_head.rd;
         w_wr_data = w_head.data;
      end
   end

   // Clear applied before set, so a fresh issue to the same rd stays busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop && (w_head.rd != '0)) w_busy_nxt[w_head.rd] = 1'b0;
      if (bus.ld_issue && (bus.ld_issue_rd != '0)) w_busy_nxt[bus.ld_issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) r_rf[i] <= '0;
      end else if (w_wr_en) begin
         r_rf[w_wr_rd] <= w_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy    <= '0;
         r_wb_en   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_wb_en   <= w_wr_en;
         r_wb_rd   <= w_wr_rd;
         r_wb_data <= w_wr_data;
      end
   end

   // x0 is never written, so the array already reads 0 there; w_wr_en implies rd != 0.
   assign bus.rs1_data = (w_wr_en && (bus.rs1_addr == w_wr_rd)) ? w_wr_data : r_rf[bus.rs1_addr];
   assign bus.rs2_data = (w_wr_en && (bus.rs2_addr == w_wr_rd)) ? w_wr_data : r_rf[bus.rs2_addr];
   assign bus.rs1_busy = r_busy[bus.rs1_addr];
   assign bus.rs2_busy = r_busy[bus.rs2_addr];

   assign bus.ld_ready = !w_full;
   assign bus.lq_count = w_count;
   assign bus.wb_en    = r_wb_en;
   assign bus.wb_rd    = r_wb_rd;
   assign bus.wb_data  = r_wb_data;

endmodule

// File: tb/tb_reg_wb_unit.sv
// Bench for reg_wb_unit: directed vector table, mid-run reset sequence, then
// random traffic against a queue-based reference model.
module tb_reg_wb_unit;
   import reg_wb_unit_pkg::*;

   localparam int unsigned D = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   reg_wb_unit_if #(.LQ_DEPTH(D)) bus ();

   reg_wb_unit #(.LQ_DEPTH(D)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic            alu_en;
      logic [4:0]      alu_rd;
      logic [XLEN-1:0] alu_data;
      logic            ldv;
      logic [4:0]      ld_rd;
      logic [XLEN-1:0] ld_data;
      logic            iss;
      logic [4:0]      iss_rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] e_rs1;
      logic [XLEN-1:0] e_rs2;
      logic            e_b1;
      logic            e_b2;
      logic            e_rdy;
      int              e_cnt;
      logic            e_wb_en;
      logic [4:0]      e_wb_rd;
      logic [XLEN-1:0] e_wb_data;
   } vec_t;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] d;
   } ent_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ae, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                        input logic is, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
      bus.alu_en = ae;  bus.alu_rd = ard;  bus.alu_data = ad;
      bus.ld_valid = lv; bus.ld_rd = lrd;  bus.ld_data = ldat;
      bus.ld_issue = is; bus.ld_issue_rd = ird;
      bus.rs1_addr = r1; bus.rs2_addr = r2;
   endtask

   function automatic vec_t mk(input logic ae, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                               input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                               input logic is, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [XLEN-1:0] er1, input logic [XLEN-1:0] er2, input logic eb1, input logic eb2,
                               input logic erdy, input int ecnt, input logic ewe, input logic [4:0] ewrd, input logic [XLEN-1:0] ewd);
      vec_t v;
      v.alu_en = ae; v.alu_rd = ard; v.alu_data = ad; v.ldv = lv; v.ld_rd = lrd; v.ld_data = ldat;
      v.iss = is; v.iss_rd = ird; v.rs1 = r1; v.rs2 = r2; v.e_rs1 = er1; v.e_rs2 = er2;
      v.e_b1 = eb1; v.e_b2 = eb2; v.e_rdy = erdy; v.e_cnt = ecnt;
      v.e_wb_en = ewe; v.e_wb_rd = ewrd; v.e_wb_data = ewd;
      return v;
   endfunction

   // Reference model state
   logic [XLEN-1:0] m_rf [32];
   bit              m_busy [32];
   ent_t            m_q [$];

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_rf[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_q.delete();
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Post-reset: every register reads zero, queue empty
      for (int r = 1; r < 32; r++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 5'(r), 5'(r));
         #1 chk("reset_rf", bus.rs1_data, '0);
      end
      chk("reset_ready", XLEN'(bus.ld_ready), XLEN'(1));
      chk("reset_count", XLEN'(bus.lq_count), '0);

      //         ae ard adata         lv lrd ldata         is ird rs1 rs2 | e_rs1        e_rs2        b1 b2 rdy cnt | we rd wdata
      vt.push_back(mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0,            0, 0,  0,  1,  0,           0,           0, 0, 1, 0,  0, 0, 0));
      vt.push_back(mk(1, 5, 32'h1234_5678, 0, 0, 0,            0, 0,  5,  0,  32'h12345678, 0,          0, 0, 1, 0,  1, 5, 32'h12345678));
      vt.push_back(mk(0, 0, 0,             0, 0, 0,            1, 7,  5,  7,  32'h12345678, 0,          0, 0, 1, 0,  0, 0, 0));
      vt.push_back(mk(0, 0, 0,             1, 7, 32'hDEAD_BEEF, 0, 0, 7,  5,  0,           32'h12345678, 1, 0, 1, 0,  0, 0, 0));
      vt.push_back(mk(0, 0, 0,             0, 0, 0,            0, 0,  7,  0,  32'hDEADBEEF, 0,          1, 0, 1, 1,  1, 7, 32'hDEADBEEF));
      vt.push_back(mk(0, 0, 0,             0, 0, 0,            0, 0,  7,  0,  32'hDEADBEEF, 0,          0, 0, 1, 0,  0, 0, 0));
      vt.push_back(mk(1, 10, 32'h10,       1, 3, 32'h33,       0, 0,  3, 10,  0,           32'h10,      0, 0, 1, 0,  1, 10, 32'h10));
      vt.push_back(mk(1, 11, 32'h11,       1, 4, 32'h44,       0, 0,  3, 11,  0,           32'h11,      0, 0, 1, 1,  1, 11, 32'h11));
      vt.push_back(mk(1, 12, 32'h12,       1, 6, 32'h66,       0, 0,  3, 12,  0,           32'h12,      0, 0, 0, 2,  1, 12, 32'h12));
      vt.push_back(mk(0, 0, 0,             1, 6, 32'h66,       0, 0,  3,  4,  32'h33,      0,           0, 0, 0, 2,  1, 3, 32'h33));
      vt.push_back(mk(0, 0, 0,             1, 6, 32'h66,       0, 0,  4,  6,  32'h44,      0,           0, 0, 1, 1,  1, 4, 32'h44));
      vt.push_back(mk(0, 0, 0,             0, 0, 0,            0, 0,  6,  4,  32'h66,      32'h44,      0, 0, 1, 1,  1, 6, 32'h66));
      vt.push_back(mk(0, 0, 0,             1, 9, 32'h99,       1, 9,  9,  6,  0,           32'h66,      0, 0, 1, 0,  0, 0, 0));
      vt.push_back(mk(0, 0, 0,             0, 0, 0,            1, 9,  9,  0,  32'h99,      0,           1, 0, 1, 1,  1, 9, 32'h99));
      vt.push_back(mk(0, 0, 0,             0, 0, 0,            0, 0,  9,  0,  32'h99,      0,           1, 0, 1, 0,  0, 0, 0));
      vt.push_back(mk(0, 0, 0,             1, 0, 32'hAB,       0, 0,  0,  9,  0,           32'h99,      0, 1, 1, 0,  0, 0, 0));
      vt.push_back(mk(0, 0, 0,             0, 0, 0,            0, 0,  0,  0,  0,           0,           0, 0, 1, 1,  0, 0, 0));
      vt.push_back(mk(0, 0, 0,             1, 13, 32'h13,      0, 0,  0, 13,  0,           0,           0, 0, 1, 0,  0, 0, 0));
      vt.push_back(mk(1, 0, 32'hFF,        0, 0, 0,            0, 0, 13,  0,  32'h13,      0,           0, 0, 1, 1,  1, 13, 32'h13));

      foreach (vt[k]) begin
         @(negedge clk);
         drive(vt[k].alu_en, vt[k].alu_rd, vt[k].alu_data, vt[k].ldv, vt[k].ld_rd, vt[k].ld_data,
               vt[k].iss, vt[k].iss_rd, vt[k].rs1, vt[k].rs2);
         #1;
         chk($sformatf("v%0d_rs1_data", k), bus.rs1_data, vt[k].e_rs1);
         chk($sformatf("v%0d_rs2_data", k), bus.rs2_data, vt[k].e_rs2);
         chk($sformatf("v%0d_rs1_busy", k), XLEN'(bus.rs1_busy), XLEN'(vt[k].e_b1));
         chk($sformatf("v%0d_rs2_busy", k), XLEN'(bus.rs2_busy), XLEN'(vt[k].e_b2));
         chk($sformatf("v%0d_ld_ready", k), XLEN'(bus.ld_ready), XLEN'(vt[k].e_rdy));
         chk($sformatf("v%0d_lq_count", k), XLEN'(bus.lq_count), XLEN'(vt[k].e_cnt));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_wb_en", k), XLEN'(bus.wb_en), XLEN'(vt[k].e_wb_en));
         if (vt[k].e_wb_en) begin
            chk($sformatf("v%0d_wb_rd", k), XLEN'(bus.wb_rd), XLEN'(vt[k].e_wb_rd));
            chk($sformatf("v%0d_wb_data", k), bus.wb_data, vt[k].e_wb_data);
         end
      end

      // Fill the queue behind ALU traffic, then reset mid-run
      @(negedge clk); drive(1, 20, 32'h20, 1, 21, 32'h21, 1, 21, 0, 0);
      @(negedge clk); drive(1, 20, 32'h20, 1, 22, 32'h22, 1, 22, 0, 0);
      @(negedge clk); drive(1, 20, 32'h20, 0, 0, 0, 0, 0, 21, 22);
      #1;
      chk("fill_count", XLEN'(bus.lq_count), XLEN'(2));
      chk("fill_ready", XLEN'(bus.ld_ready), '0);
      chk("fill_busy21", XLEN'(bus.rs1_busy), XLEN'(1));
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 21, 22);
      #2 rst = 1'b0;
      #1;
      chk("rst_count", XLEN'(bus.lq_count), '0);
      chk("rst_ready", XLEN'(bus.ld_ready), XLEN'(1));
      chk("rst_busy21", XLEN'(bus.rs1_busy), '0);
      chk("rst_busy22", XLEN'(bus.rs2_busy), '0);
      chk("rst_wb_en", XLEN'(bus.wb_en), '0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0, 0, 0, 21, 22);
         #1;
         chk("post_rst_count", XLEN'(bus.lq_count), '0);
         chk("post_rst_x21", bus.rs1_data, '0);
         chk("post_rst_x22", bus.rs2_data, '0);
         @(posedge clk);
         #1 chk("post_rst_wb_en", XLEN'(bus.wb_en), '0);
      end

      // Random traffic against the reference model, starting from reset state
      model_reset();
      for (int c = 0; c < 600; c++) begin
         logic            ae, lv, is;
         logic [4:0]      ard, lrd, ird, r1, r2, wrd;
         logic [XLEN-1:0] ad, ldat, wdat, e1, e2;
         bit              we, pop, rdy;
         @(negedge clk);
         ae = 1'($urandom_range(0, 1));  ard = 5'($urandom_range(0, 7));  ad = XLEN'($urandom);
         lv = 1'($urandom_range(0, 1));  lrd = 5'($urandom_range(0, 7));  ldat = XLEN'($urandom);
         is = ($urandom_range(0, 3) == 0); ird = 5'($urandom_range(0, 7));
         r1 = 5'($urandom_range(0, 7));  r2 = 5'($urandom_range(0, 7));
         drive(ae, ard, ad, lv, lrd, ldat, is, ird, r1, r2);

         we = 0; pop = 0; wrd = '0; wdat = '0;
         if (ae && ard != 0) begin
            we = 1; wrd = ard; wdat = ad;
         end else if (m_q.size() > 0) begin
            pop = 1;
            if (m_q[0].rd != 0) begin
               we = 1; wrd = m_q[0].rd; wdat = m_q[0].d;
            end
         end
         rdy = (m_q.size() < D);
         e1 = (r1 != 0 && we && r1 == wrd) ? wdat : m_rf[r1];
         e2 = (r2 != 0 && we && r2 == wrd) ? wdat : m_rf[r2];
         #1;
         chk("rnd_rs1_data", bus.rs1_data, e1);
         chk("rnd_rs2_data", bus.rs2_data, e2);
         chk("rnd_rs1_busy", XLEN'(bus.rs1_busy), XLEN'(m_busy[r1]));
         chk("rnd_rs2_busy", XLEN'(bus.rs2_busy), XLEN'(m_busy[r2]));
         chk("rnd_ld_ready", XLEN'(bus.ld_ready), XLEN'(rdy));
         chk("rnd_lq_count", XLEN'(bus.lq_count), XLEN'(m_q.size()));
         @(posedge clk);
         #1;
         chk("rnd_wb_en", XLEN'(bus.wb_en), XLEN'(we));
         if (we) begin
            chk("rnd_wb_rd", XLEN'(bus.wb_rd), XLEN'(wrd));
            chk("rnd_wb_data", bus.wb_data, wdat);
         end

         if (pop) begin
            ent_t e;
            e = m_q.pop_front();
            if (e.rd != 0) m_busy[e.rd] = 1'b0;
         end
         if (is && ird != 0) m_busy[ird] = 1'b1;
         if (we) m_rf[wrd] = wdat;
         if (lv && rdy) begin
            ent_t n;
            n.rd = lrd; n.d = ldat;
            m_q.push_back(n);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
